// File: rtl/spi_byte_slave_if.sv
// spi_byte_slave_if: byte handshake between the SPI slave front end and the command decoder
interface spi_byte_slave_if;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       clr_overrun;
  logic [7:0] tx_data;
  logic       frame_active;
  logic       frame_end;
  modport slave (
    output rx_data, rx_first, rx_valid, rx_overrun, frame_active, frame_end,
    input  rx_ready, clr_overrun, tx_data
  );
  modport master (
    input  rx_data, rx_first, rx_valid, rx_overrun, frame_active, frame_end,
    output rx_ready, clr_overrun, tx_data
  );
endinterface

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: mode-0 SPI slave sampled in clk, MSB-first bytes into a one-deep holding register
module spi_byte_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_mosi,
  input  logic spi_cs,
  output logic spi_miso,
  spi_byte_slave_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  logic [SYNC_STAGES-1:0] sck_sy, mosi_sy, cs_sy;
  logic                   sck_h, mosi_h, cs_h;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic [SYNC_STAGES:0]   fill;
  logic                   armed;
  state_t                 state;
  logic [2:0]             cnt;
  logic [6:0]             rx_sh;
  logic [7:0]             tx_sh;
  logic                   first;
  logic                   skip;
  logic [7:0]             rx_byte;
  assign rx_byte  = {rx_sh, mosi_h};
  assign spi_miso = bus.frame_active & tx_sh[7];
  // Strobes are registered so they line up with the mosi history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sy   <= '0;
      mosi_sy  <= '0;
      cs_sy    <= '1;
      sck_h    <= 1'b0;
      mosi_h   <= 1'b0;
      cs_h     <= 1'b1;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
      fill     <= '0;
      armed    <= 1'b0;
    end else begin
      sck_sy   <= {sck_sy[SYNC_STAGES-2:0], spi_sck};
      mosi_sy  <= {mosi_sy[SYNC_STAGES-2:0], spi_mosi};
      cs_sy    <= {cs_sy[SYNC_STAGES-2:0], spi_cs};
      sck_h    <= sck_sy[SYNC_STAGES-1];
      mosi_h   <= mosi_sy[SYNC_STAGES-1];
      cs_h     <= cs_sy[SYNC_STAGES-1];
      sck_rise <= sck_sy[SYNC_STAGES-1] & ~sck_h;
      sck_fall <= ~sck_sy[SYNC_STAGES-1] & sck_h;
      cs_fall  <= ~cs_sy[SYNC_STAGES-1] & cs_h;
      cs_rise  <= cs_sy[SYNC_STAGES-1] & ~cs_h;
      fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
      // A frame may only start once CS has been seen high after reset.
      armed    <= armed | (fill[SYNC_STAGES] & cs_h);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      rx_sh            <= '0;
      tx_sh            <= '0;
      first            <= 1'b0;
      skip             <= 1'b0;
      bus.rx_data      <= '0;
      bus.rx_first     <= 1'b0;
      bus.rx_valid     <= 1'b0;
      bus.rx_overrun   <= 1'b0;
      bus.frame_active <= 1'b0;
      bus.frame_end    <= 1'b0;
    end else begin
      bus.frame_end <= 1'b0;
      if (bus.rx_valid & bus.rx_ready) bus.rx_valid <= 1'b0;
      if (bus.clr_overrun) bus.rx_overrun <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall & armed) begin
          state            <= SHIFT;
          cnt              <= '0;
          tx_sh            <= bus.tx_data;
          first            <= 1'b1;
          skip             <= 1'b0;
          bus.frame_active <= 1'b1;
        end
      end else if (cs_rise) begin
        state            <= IDLE;
        cnt              <= '0;
        bus.frame_end    <= 1'b1;
        bus.frame_active <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_sh <= rx_byte[6:0];
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            first <= 1'b0;
            skip  <= 1'b1;
            tx_sh <= bus.tx_data;
            if (~bus.rx_valid | bus.rx_ready) begin
              bus.rx_data  <= rx_byte;
              bus.rx_first <= first;
              bus.rx_valid <= 1'b1;
            end else begin
              bus.rx_overrun <= 1'b1;
            end
          end
        end
        if (sck_fall) begin
          skip  <= 1'b0;
          tx_sh <= skip ? tx_sh : {tx_sh[6:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_byte_slave.sv
// tb_spi_byte_slave: directed and randomized frames against an SPI master model
module tb_spi_byte_slave;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0, mosi = 1'b0, cs = 1'b1;
  logic miso, miso3;
  int   passed = 0, total = 0;
  always #5 clk = ~clk;
  spi_byte_slave_if i2 ();
  spi_byte_slave_if i3 ();
  assign i3.rx_ready    = i2.rx_ready;
  assign i3.clr_overrun = i2.clr_overrun;
  assign i3.tx_data     = i2.tx_data;
  spi_byte_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_cs(cs),
    .spi_miso(miso), .bus(i2)
  );
  spi_byte_slave #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_cs(cs),
    .spi_miso(miso3), .bus(i3)
  );
  typedef struct {logic [7:0] d; logic f;} rx_t;
  rx_t hq[$];
  int  fe_cnt = 0, valid_cnt = 0;
  always @(negedge clk) begin
    if (i2.rx_valid && i2.rx_ready) hq.push_back('{d: i2.rx_data, f: i2.rx_first});
    if (i2.frame_end) fe_cnt++;
    if (i2.rx_valid) valid_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    cyc(H);
    m = miso;
    sck = 1'b1;
    cyc(H);
    sck = 1'b0;
  endtask
  task automatic xfer(input logic [7:0] b, input logic [7:0] next_tx, output logic [7:0] m);
    logic bit_m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], bit_m);
      m[i] = bit_m;
      if (i == 7) i2.tx_data = next_tx;
    end
  endtask
  task automatic cs_lo();
    cs = 1'b0;
    cyc(8);
  endtask
  task automatic cs_hi();
    cyc(H);
    cs = 1'b1;
    cyc(12);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] m, m0, m1, tx0;
    logic       bm;
    logic [7:0] d[4];
    logic [7:0] t[5];
    logic [7:0] f1[4];
    int         h0, fe0, v0, n;
    f1 = '{8'hC0, 8'h70, 8'hAA, 8'hCC};
    i2.rx_ready = 1'b0;
    i2.clr_overrun = 1'b0;
    i2.tx_data = 8'h00;
    cyc(4);
    chk("rst_rx_data", i2.rx_data, 0);
    chk("rst_rx_first", i2.rx_first, 0);
    chk("rst_rx_valid", i2.rx_valid, 0);
    chk("rst_overrun", i2.rx_overrun, 0);
    chk("rst_miso", miso, 0);
    chk("rst_frame_active", i2.frame_active, 0);
    chk("rst_frame_end", i2.frame_end, 0);
    rst = 1'b0;
    cyc(6);
    // Four-byte frame drained as it arrives
    i2.rx_ready = 1'b1;
    h0 = hq.size();
    fe0 = fe_cnt;
    cs_lo();
    chk("t1_frame_active", i2.frame_active, 1);
    for (int k = 0; k < 4; k++) xfer(f1[k], 8'h00, m);
    cs_hi();
    chk("t1_count", hq.size() - h0, 4);
    for (int k = 0; k < 4; k++) begin
      if (hq.size() > h0 + k) begin
        chk("t1_data", hq[h0+k].d, f1[k]);
        chk("t1_first", hq[h0+k].f, k == 0);
      end
    end
    chk("t1_frame_end", fe_cnt - fe0, 1);
    chk("t1_overrun", i2.rx_overrun, 0);
    chk("t1_inactive", i2.frame_active, 0);
    // Consumer stalled: second byte overruns
    i2.rx_ready = 1'b0;
    cs_lo();
    xfer(8'h71, 8'h00, m);
    xfer(8'h25, 8'h00, m);
    cs_hi();
    chk("t2_valid", i2.rx_valid, 1);
    chk("t2_data", i2.rx_data, 8'h71);
    chk("t2_first", i2.rx_first, 1);
    chk("t2_overrun", i2.rx_overrun, 1);
    i2.clr_overrun = 1'b1;
    cyc(1);
    i2.clr_overrun = 1'b0;
    chk("t2_clr_overrun", i2.rx_overrun, 0);
    i2.rx_ready = 1'b1;
    cyc(1);
    chk("t2_drain", i2.rx_valid, 0);
    // Partial byte then fresh frame
    cs_lo();
    for (int k = 0; k < 5; k++) spi_bit(1'b1, bm);
    cs_hi();
    h0 = hq.size();
    cs_lo();
    xfer(8'h3C, 8'h00, m);
    cs_hi();
    chk("t3_count", hq.size() - h0, 1);
    if (hq.size() > h0) begin
      chk("t3_data", hq[h0].d, 8'h3C);
      chk("t3_first", hq[h0].f, 1);
    end
    // Reply bytes on MISO
    i2.tx_data = 8'hA5;
    cs_lo();
    xfer(8'h00, 8'h5A, m0);
    xfer(8'h00, 8'h00, m1);
    chk("t4_miso_b0", m0, 8'hA5);
    chk("t4_miso_b1", m1, 8'h5A);
    cs_hi();
    chk("t4_miso_idle", miso, 0);
    // Reset mid-byte with CS held low
    m = 8'h96;
    v0 = valid_cnt;
    cs_lo();
    for (int i = 7; i >= 4; i--) spi_bit(m[i], bm);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) spi_bit(m[i], bm);
    xfer(8'hFF, 8'h00, m0);
    chk("t5_idle_after_rst", i2.frame_active, 0);
    cs_hi();
    chk("t5_no_valid", valid_cnt - v0, 0);
    h0 = hq.size();
    cs_lo();
    xfer(8'h96, 8'h00, m0);
    cs_hi();
    chk("t5_count", hq.size() - h0, 1);
    if (hq.size() > h0) chk("t5_data", hq[h0].d, 8'h96);
    // Random frames: data echoed in order, replies follow tx_data
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < 5; k++) t[k] = 8'($urandom);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      h0 = hq.size();
      i2.tx_data = t[0];
      cs_lo();
      for (int k = 0; k < n; k++) begin
        xfer(d[k], t[k+1], m);
        chk("rnd_miso", m, t[k]);
      end
      cs_hi();
      chk("rnd_count", hq.size() - h0, n);
      for (int k = 0; k < n; k++) begin
        if (hq.size() > h0 + k) begin
          chk("rnd_data", hq[h0+k].d, d[k]);
          chk("rnd_first", hq[h0+k].f, k == 0);
        end
      end
    end
    // Three-stage synchronizer latency on the last rise
    tx0 = 8'h81;
    cs_lo();
    for (int i = 7; i >= 1; i--) spi_bit(tx0[i], bm);
    mosi = tx0[0];
    cyc(H);
    sck = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("t6_valid_early", i3.rx_valid, 0);
    @(posedge clk);
    #2;
    chk("t6_valid_on_time", i3.rx_valid, 1);
    chk("t6_data", i3.rx_data, 8'h81);
    cyc(H);
    sck = 1'b0;
    cs_hi();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
